regfile_scoreboard: RTL and testbench
=====================================

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning register data width.
REQ-002 SHALL have parameter NUM_REGS, default 32, meaning register count; AW = clog2(NUM_REGS); CW = clog2(NUM_REGS+1).
REQ-003 SHALL have parameter NUM_RD_PORTS, default 2, meaning number of independent read ports (1..4).
REQ-004 SHALL have ports, in order: clk in 1, single clock, all state updates on rising edge.
REQ-005 rst in 1: reset, asynchronous, active-high.
REQ-006 rd_addr in NUM_RD_PORTS*AW: packed read addresses, port p at bits [p*AW +: AW].
REQ-007 rd_used in NUM_RD_PORTS: port p operand actually consumed by the decoding instruction.
REQ-008 rd_data out NUM_RD_PORTS*XLEN: packed read data, combinational.
REQ-009 rd_busy out NUM_RD_PORTS: scoreboard busy bit of each addressed register.
REQ-010 stall out 1: OR over p of (rd_used[p] AND rd_busy[p]).
REQ-011 issue_valid in 1, issue_rd in AW: instruction issued that will write issue_rd.
REQ-012 RegWrite in 1, write_id in AW, write_data in XLEN: writeback port.
REQ-013 flush in 1: pipeline flush, clears all pending marks.
REQ-014 pending_count out CW: number of registers currently marked busy.

Function
REQ-015 Register 0 SHALL read as 0, SHALL ignore writes, SHALL never be busy; issue_rd==0 SHALL be ignored.
REQ-016 RegWrite with write_id!=0 SHALL update that register at the rising edge.
REQ-017 issue_valid with issue_rd!=0 and flush low SHALL set busy[issue_rd] at the rising edge.
REQ-018 RegWrite with write_id!=0 SHALL clear busy[write_id] at the rising edge unless REQ-019 applies.
REQ-019 Issue and writeback to the same register in one cycle: busy SHALL end set (issue wins), data SHALL still be written.
REQ-020 flush high: all busy bits SHALL clear, same-cycle issue SHALL be ignored; same-cycle writeback data SHALL still be written.
REQ-021 Writeback to a non-busy register: data written, busy and pending_count unchanged.
REQ-022 Issue to an already-busy register: busy stays set, pending_count unchanged.
REQ-023 pending_count SHALL equal the population count of busy bits after every edge; it SHALL never exceed NUM_REGS-1 nor wrap.
REQ-024 pending_count SHALL be registered; it SHALL be updated by +1, -1, 0 or cleared in a single cycle, consistent with REQ-017..REQ-022.
REQ-025 Multiple read ports addressing the same register SHALL return identical data and busy.

Reset
REQ-026 While rst is high, all registers, all busy bits and pending_count SHALL be 0, independent of clk.
REQ-027 Consequently during and after reset: rd_data = 0, rd_busy = 0, stall = 0.
REQ-028 Reset asserted mid-operation SHALL discard same-cycle issue and writeback.

Configuration
REQ-029 Macro REGFILE_BYPASS_EN SHALL select write-through bypass.
REQ-030 With REGFILE_BYPASS_EN defined: a port whose rd_addr equals write_id (!=0) while RegWrite is high SHALL return write_data and rd_busy=0 in the same cycle, unless issue to that register is also asserted that cycle (then rd_busy=1).
REQ-031 Without REGFILE_BYPASS_EN: rd_data and rd_busy SHALL reflect stored state only; new value and cleared busy become visible the cycle after writeback.

Verification
REQ-032 Reset: rst=1 mid-run with busy regs 3,5 -> rd_data=0, rd_busy=0, pending_count=0 immediately, no clk needed.
REQ-033 Issue rd=3, next cycle rd_addr0=3, rd_used0=1 -> rd_busy0=1, stall=1, pending_count=1; RegWrite id=3 data=0x00000007 -> next cycle rd_data0=0x7, stall=0, pending_count=0.
REQ-034 Same-cycle issue rd=5 and RegWrite id=5 data=0xA5 -> after edge busy[5]=1, reg5=0xA5, pending_count unchanged from prior +1.
REQ-035 Write id=0 data=0xFFFFFFFF and issue rd=0 -> reg0 reads 0, pending_count unchanged, stall=0.
REQ-036 Issue rd=2,4,6 over three cycles then flush with issue rd=7 -> pending_count=0, no busy bits, busy[7]=0.
REQ-037 Bypass: reg9 busy, rd_addr1=9, RegWrite id=9 data=0x1234 -> with REGFILE_BYPASS_EN rd_data1=0x1234, rd_busy1=0 same cycle; without it old value and rd_busy1=1 until next edge.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Register file with per-register busy scoreboard, issue/writeback tracking and flush.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data and busy-clear to the read ports.
module regfile_scoreboard_rdport #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic [DEPTH-1:0][XLEN-1:0] i_regs,
  input  logic [DEPTH-1:0]           i_busy,
  input  logic [AW-1:0]              i_addr,
  input  logic                       i_wr_en,
  input  logic [AW-1:0]              i_wid,
  input  logic [XLEN-1:0]            i_wdata,
  input  logic                       i_iss_en,
  input  logic [AW-1:0]              i_iss_rd,
  output logic [XLEN-1:0]            o_data,
  output logic                       o_busy
);
  // Rows outside 1..NUM_REGS-1 are never written or marked, so a plain index is safe.
  logic [XLEN-1:0] w_sdata;
  logic            w_sbusy;
  assign w_sdata = i_regs[i_addr];
  assign w_sbusy = i_busy[i_addr];

`ifdef REGFILE_BYPASS_EN
  logic w_byp;
  assign w_byp  = i_wr_en && (i_wid == i_addr);
  assign o_data = w_byp ? i_wdata : w_sdata;
  assign o_busy = w_byp ? (i_iss_en && (i_iss_rd == i_addr)) : w_sbusy;
`else
  logic w_unused;
  assign w_unused = ^{i_wr_en, i_wid, i_wdata, i_iss_en, i_iss_rd};
  assign o_data   = w_sdata;
  assign o_busy   = w_sbusy;
`endif
endmodule

module regfile_scoreboard #(
  parameter  int XLEN         = 32,
  parameter  int NUM_REGS     = 32,
  parameter  int NUM_RD_PORTS = 2,
  localparam int AW           = $clog2(NUM_REGS),
  localparam int CW           = $clog2(NUM_REGS + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_RD_PORTS*AW-1:0]   rd_addr,
  input  logic [NUM_RD_PORTS-1:0]      rd_used,
  output logic [NUM_RD_PORTS*XLEN-1:0] rd_data,
  output logic [NUM_RD_PORTS-1:0]      rd_busy,
  output logic                         stall,
  input  logic                         issue_valid,
  input  logic [AW-1:0]                issue_rd,
  input  logic                         RegWrite,
  input  logic [AW-1:0]                write_id,
  input  logic [XLEN-1:0]              write_data,
  input  logic                         flush,
  output logic [CW-1:0]                pending_count
);
  localparam int              DEPTH    = 1 << AW;
  localparam logic [DEPTH-1:0] ALL1    = '1;
  // Bit r set for every architecturally writable register (1..NUM_REGS-1).
  localparam logic [DEPTH-1:0] REG_MASK = (ALL1 >> (DEPTH - NUM_REGS)) & ~DEPTH'(1);

  logic [DEPTH-1:0][XLEN-1:0] r_regs;
  logic [DEPTH-1:0]           r_busy;
  logic [CW-1:0]              r_cnt;

  logic             w_wr_en, w_iss_en, w_same, w_set, w_clr;
  logic [DEPTH-1:0] w_busy_nxt;
  logic [CW-1:0]    w_cnt_nxt;

  assign w_wr_en  = RegWrite && REG_MASK[write_id];
  assign w_iss_en = issue_valid && REG_MASK[issue_rd] && !flush;
  assign w_same   = w_iss_en && w_wr_en && (issue_rd == write_id);
  assign w_set    = w_iss_en && !r_busy[issue_rd];
  assign w_clr    = w_wr_en && r_busy[write_id] && !w_same && !flush;

  always_comb begin
    w_busy_nxt = r_busy;
    if (flush) begin
      w_busy_nxt = '0;
    end else begin
      if (w_wr_en)  w_busy_nxt[write_id] = 1'b0;
      if (w_iss_en) w_busy_nxt[issue_rd] = 1'b1;
    end
  end

  // Incremental count tracks the busy popcount without an adder tree.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (flush)                w_cnt_nxt = '0;
    else if (w_set && !w_clr) w_cnt_nxt = r_cnt + CW'(1);
    else if (w_clr && !w_set) w_cnt_nxt = r_cnt - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_regs <= '0;
      r_busy <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_wr_en) r_regs[write_id] <= write_data;
      r_busy <= w_busy_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end

  logic w_byp_wr;
  assign w_byp_wr = w_wr_en && !rst;

  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
    regfile_scoreboard_rdport #(.XLEN(XLEN), .DEPTH(DEPTH), .AW(AW)) u_rd (
      .i_regs   (r_regs),
      .i_busy   (r_busy),
      .i_addr   (rd_addr[p*AW +: AW]),
      .i_wr_en  (w_byp_wr),
      .i_wid    (write_id),
      .i_wdata  (write_data),
      .i_iss_en (w_iss_en),
      .i_iss_rd (issue_rd),
      .o_data   (rd_data[p*XLEN +: XLEN]),
      .o_busy   (rd_busy[p])
    );
  end

  assign stall         = |(rd_used & rd_busy);
  assign pending_count = r_cnt;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench: stimulus pushes expected outputs from a register/busy-set model; a negedge monitor compares.
module tb_regfile_scoreboard;
  localparam int XLEN = 32;
  localparam int NR   = 32;
  localparam int NRP  = 2;
  localparam int AW   = 5;
  localparam int CW   = 6;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NRP*AW-1:0]    rd_addr;
  logic [NRP-1:0]       rd_used;
  logic [NRP*XLEN-1:0]  rd_data;
  logic [NRP-1:0]       rd_busy;
  logic                 stall;
  logic                 issue_valid;
  logic [AW-1:0]        issue_rd;
  logic                 RegWrite;
  logic [AW-1:0]        write_id;
  logic [XLEN-1:0]      write_data;
  logic                 flush;
  logic [CW-1:0]        pending_count;

  regfile_scoreboard #(.XLEN(XLEN), .NUM_REGS(NR), .NUM_RD_PORTS(NRP)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_used(rd_used), .rd_data(rd_data),
    .rd_busy(rd_busy), .stall(stall), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .RegWrite(RegWrite), .write_id(write_id), .write_data(write_data), .flush(flush),
    .pending_count(pending_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NRP*XLEN-1:0] data;
    logic [NRP-1:0]      busy;
    logic                stall;
    logic [CW-1:0]       pend;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: register contents and the set of registers awaiting writeback.
  logic [XLEN-1:0] m_regs [NR];
  bit              m_busy [NR];

  function automatic int busy_count();
    int n = 0;
    for (int i = 0; i < NR; i++) if (m_busy[i]) n++;
    return n;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("rd_data",       128'(rd_data),       128'(e.data));
        chk("rd_busy",       128'(rd_busy),       128'(e.busy));
        chk("stall",         128'(stall),         128'(e.stall));
        chk("pending_count", 128'(pending_count), 128'(e.pend));
      end
    end
  end

  task automatic cyc(input logic r, input logic iv, input logic [AW-1:0] ird,
                     input logic we, input logic [AW-1:0] wid, input logic [XLEN-1:0] wd,
                     input logic fl, input logic [NRP*AW-1:0] ra, input logic [NRP-1:0] ru);
    exp_t e;
    @(posedge clk); #1;
    rst = r; issue_valid = iv; issue_rd = ird; RegWrite = we; write_id = wid;
    write_data = wd; flush = fl; rd_addr = ra; rd_used = ru;
    e.stall = 1'b0;
    for (int p = 0; p < NRP; p++) begin
      logic [AW-1:0]   a;
      logic [XLEN-1:0] d;
      logic            b;
      a = ra[p*AW +: AW];
      d = (a == 0) ? '0 : m_regs[a];
      b = (a != 0) && m_busy[a];
`ifdef REGFILE_BYPASS_EN
      if (we && wid == a && a != 0) begin
        d = wd;
        b = iv && !fl && (ird == a);
      end
`endif
      if (r) begin d = '0; b = 1'b0; end
      e.data[p*XLEN +: XLEN] = d;
      e.busy[p] = b;
      if (ru[p] && b) e.stall = 1'b1;
    end
    e.pend = r ? '0 : CW'(busy_count());
    q.push_back(e);
    // Next-state of the model, visible after the coming edge.
    if (r) begin
      for (int i = 0; i < NR; i++) begin m_regs[i] = '0; m_busy[i] = 0; end
    end else begin
      if (we && wid != 0) m_regs[wid] = wd;
      if (fl) begin
        for (int i = 0; i < NR; i++) m_busy[i] = 0;
      end else begin
        if (we && wid != 0) m_busy[wid] = 0;
        if (iv && ird != 0) m_busy[ird] = 1;
      end
    end
  endtask

  task automatic idle(input logic [NRP*AW-1:0] ra, input logic [NRP-1:0] ru);
    cyc(0, 0, '0, 0, '0, '0, 0, ra, ru);
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    return ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, NR-1)) : AW'($urandom_range(0, 7));
  endfunction

  initial begin : stim
    rst = 1'b1; issue_valid = 0; issue_rd = '0; RegWrite = 0; write_id = '0;
    write_data = '0; flush = 0; rd_addr = '0; rd_used = '0;
    for (int i = 0; i < NR; i++) begin m_regs[i] = '0; m_busy[i] = 0; end

    cyc(1, 1, 5'd4, 1, 5'd4, 32'h55, 0, {5'd4, 5'd0}, 2'b11);   // in reset
    idle({5'd4, 5'd0}, 2'b11);
    // Issue/writeback round trip on r3
    cyc(0, 1, 5'd3, 0, '0, '0, 0, '0, 2'b00);
    idle({5'd1, 5'd3}, 2'b01);
    cyc(0, 0, '0, 1, 5'd3, 32'h7, 0, {5'd1, 5'd3}, 2'b01);
    idle({5'd3, 5'd3}, 2'b11);
    // Issue and writeback to r5 in the same cycle
    cyc(0, 1, 5'd5, 1, 5'd5, 32'hA5, 0, {5'd5, 5'd5}, 2'b11);
    idle({5'd5, 5'd3}, 2'b11);
    // Register 0 ignores writes and issues
    cyc(0, 1, 5'd0, 1, 5'd0, 32'hFFFF_FFFF, 0, {5'd0, 5'd0}, 2'b11);
    idle({5'd0, 5'd0}, 2'b11);
    // Flush wins over same-cycle issue
    cyc(0, 1, 5'd2, 0, '0, '0, 0, '0, 2'b00);
    cyc(0, 1, 5'd4, 0, '0, '0, 0, '0, 2'b00);
    cyc(0, 1, 5'd6, 0, '0, '0, 0, {5'd4, 5'd2}, 2'b11);
    cyc(0, 1, 5'd7, 1, 5'd6, 32'hBEEF, 1, {5'd6, 5'd7}, 2'b11);
    idle({5'd6, 5'd7}, 2'b11);
    // Writeback to busy r9 while port 1 reads it
    cyc(0, 1, 5'd9, 0, '0, '0, 0, '0, 2'b00);
    cyc(0, 0, '0, 1, 5'd9, 32'h1234, 0, {5'd9, 5'd3}, 2'b10);
    idle({5'd9, 5'd9}, 2'b11);
    cyc(0, 1, 5'd9, 1, 5'd9, 32'h4321, 0, {5'd9, 5'd9}, 2'b11);
    // Writeback to a non-busy register
    cyc(0, 0, '0, 1, 5'd12, 32'hC0DE, 0, {5'd12, 5'd9}, 2'b11);
    idle({5'd12, 5'd9}, 2'b11);
    // Async reset mid-run with r3, r5 busy; same-cycle traffic discarded
    cyc(0, 1, 5'd3, 0, '0, '0, 0, '0, 2'b00);
    cyc(0, 1, 5'd5, 0, '0, '0, 0, {5'd5, 5'd3}, 2'b11);
    cyc(1, 1, 5'd8, 1, 5'd3, 32'hDEAD, 0, {5'd5, 5'd3}, 2'b11);
    idle({5'd5, 5'd3}, 2'b11);

    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 79) == 0), 1'($urandom_range(0, 1)), rnd_addr(),
          1'($urandom_range(0, 1)), rnd_addr(), $urandom(),
          ($urandom_range(0, 19) == 0), {rnd_addr(), rnd_addr()}, 2'($urandom_range(0, 3)));
    end
    idle('0, '0);

    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
